// File: rtl/lut_table_loader_pkg.sv
// ---------------------------------------------------------------------------
// lut_loader_pkg
//
// Shared definitions for the runtime-programmable LUT neuron (lut_table_loader)
// and its table storage (lut_table_ram).
//
// Contents:
//   load_state_t   : load FSM states {EMPTY, LOADING, READY}
//   calcNumWords() : number of config data words needed to fill one table
//   calcIdxWidth() : width of the beat index counter (must reach N, which is
//                    the position of the optional parity beat)
//   IDX_W          : index width for the default geometry (6-in, 1-out, 8-bit)
//
// Optional feature macro used by the top level: LUT_PARITY_EN
// ---------------------------------------------------------------------------
package lut_loader_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } load_state_t;

    localparam int DEF_IN_BITS   = 6;
    localparam int DEF_OUT_BITS  = 1;
    localparam int DEF_WORD_BITS = 8;

    // The table holds 2^inBits entries of outBits each, streamed wordBits at
    // a time, so the word count is the total table size over the word width.
    function automatic int calcNumWords(input int inBits, input int outBits, input int wordBits);
        return ((1 << inBits) * outBits) / wordBits;
    endfunction

    // The index has to be able to hold N itself, not just N-1, because the
    // parity beat (when enabled) arrives at index N.
    function automatic int calcIdxWidth(input int numWords);
        return $clog2(numWords + 1);
    endfunction

    localparam int DEF_N_WORDS = calcNumWords(DEF_IN_BITS, DEF_OUT_BITS, DEF_WORD_BITS);
    localparam int IDX_W       = calcIdxWidth(DEF_N_WORDS);

endpackage

// File: rtl/lut_table_ram.sv
// ---------------------------------------------------------------------------
// lut_table_ram
//
// Distributed table storage for one LUT neuron. The table is kept as one flat
// bit vector of 2^IN_BITS * OUT_BITS bits: config words land on word-aligned
// slices, lookups read OUT_BITS-wide entry slices. Read data is registered.
// The storage itself has no reset; only the read register is cleared so the
// neuron output is a known 0 out of reset.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset (read register only)
//   i_wr_en    in   write one config word
//   i_wr_addr  in   word index being written
//   i_wr_data  in   config word, LSB maps to the lowest table bit of the slice
//   i_rd_en    in   capture the addressed entry into the read register
//   i_rd_addr  in   entry address (neuron input vector)
//   o_rd_data  out  registered entry
// ---------------------------------------------------------------------------
module lut_table_ram
    import lut_loader_pkg::*;
#(
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 1,
    parameter int WORD_BITS = 8,
    parameter int WADDR_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [WADDR_W-1:0]   i_wr_addr,
    input  logic [WORD_BITS-1:0] i_wr_data,
    input  logic                 i_rd_en,
    input  logic [IN_BITS-1:0]   i_rd_addr,
    output logic [OUT_BITS-1:0]  o_rd_data
);

    localparam int N_WORDS    = calcNumWords(IN_BITS, OUT_BITS, WORD_BITS);
    localparam int TABLE_BITS = N_WORDS * WORD_BITS;

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [TABLE_BITS-1:0] r_bits;
    logic [OUT_BITS-1:0]   r_rdData;

    // Write port: each accepted config word overwrites its word-aligned slice.
    // Kept reset-free so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_bits[int'(i_wr_addr) * WORD_BITS +: WORD_BITS] <= i_wr_data;
        end
    end

    // Read port: a lookup registers its entry and the value holds until the
    // next lookup, giving the one-cycle lookup latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdData <= '0;
        end else if (i_rd_en) begin
            r_rdData <= r_bits[int'(i_rd_addr) * OUT_BITS +: OUT_BITS];
        end
    end

    assign o_rd_data = r_rdData;

endmodule

// File: rtl/lut_table_loader.sv
// ---------------------------------------------------------------------------
// lut_table_loader
//
// Runtime-programmable LUT neuron. A truth table arrives as a valid/ready word
// stream (word k fills table bits [k*WORD_BITS +: WORD_BITS], LSB first); once
// a well-formed load completes the block answers registered lookups.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   i_cfg_valid  in   config word present
//   o_cfg_ready  out  config word accepted (1 in every state once out of reset)
//   i_cfg_data   in   config word
//   i_cfg_last   in   final word of a table load
//   i_in_valid   in   lookup request (dropped unless READY and no config beat)
//   i_in_data    in   lookup address
//   o_out_valid  out  lookup result valid, one cycle after the request
//   o_out_data   out  table entry for the requested address
//   o_loaded     out  table complete and usable
//   o_err        out  one-cycle pulse on a malformed load
//
// Optional feature: define LUT_PARITY_EN to require an extra final beat
// carrying the XOR of all data words. That beat is checked, never stored.
// ---------------------------------------------------------------------------
module lut_table_loader
    import lut_loader_pkg::*;
#(
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 1,
    parameter int WORD_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [WORD_BITS-1:0] i_cfg_data,
    input  logic                 i_cfg_last,
    input  logic                 i_in_valid,
    input  logic [IN_BITS-1:0]   i_in_data,
    output logic                 o_out_valid,
    output logic [OUT_BITS-1:0]  o_out_data,
    output logic                 o_loaded,
    output logic                 o_err
);

    localparam int N_WORDS = calcNumWords(IN_BITS, OUT_BITS, WORD_BITS);
    localparam int LOC_IDX_W = calcIdxWidth(N_WORDS);
    localparam int WADDR_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

`ifdef LUT_PARITY_EN
    localparam int FINAL_BEAT = N_WORDS;
`else
    localparam int FINAL_BEAT = N_WORDS - 1;
`endif

    localparam logic [LOC_IDX_W-1:0] FINAL_IDX = LOC_IDX_W'(FINAL_BEAT);

    load_state_t            r_state;
    load_state_t            w_nextState;
    logic [LOC_IDX_W-1:0]   r_idx;
    logic [LOC_IDX_W-1:0]   w_nextIdx;
    logic [LOC_IDX_W-1:0]   w_curIdx;
    logic                   r_cfgReady;
    logic                   r_outValid;
    logic                   r_err;
    logic                   w_errNext;
    logic                   w_beat;
    logic                   w_isFinal;
    logic                   w_wrEn;
    logic                   w_lookup;
    logic                   w_parityOk;
    logic [WADDR_W-1:0]     w_wrAddr;

`ifdef LUT_PARITY_EN
    localparam logic [LOC_IDX_W-1:0] LAST_DATA_IDX = LOC_IDX_W'(N_WORDS - 1);

    logic [WORD_BITS-1:0]   r_parity;
    logic [WORD_BITS-1:0]   w_parityAcc;
    logic [WORD_BITS-1:0]   w_parityNext;
`endif

    assign w_beat   = i_cfg_valid && r_cfgReady;
    assign w_wrAddr = w_curIdx[WADDR_W-1:0];

    // A beat from EMPTY or READY is always word 0 of a fresh load, so the
    // working index only comes from the counter while LOADING.
    assign w_curIdx  = (r_state == LOADING) ? r_idx : '0;
    assign w_isFinal = (w_curIdx == FINAL_IDX);

    // Lookups never stall anything: they are simply ignored unless the table
    // is valid and no config beat is touching it this cycle.
    assign w_lookup = i_in_valid && (r_state == READY) && !w_beat;

`ifdef LUT_PARITY_EN
    // The running XOR restarts with each fresh load. The parity beat itself
    // sits past the last data index and is never written to the table.
    assign w_parityAcc  = (r_state == LOADING) ? r_parity : '0;
    assign w_parityNext = w_parityAcc ^ i_cfg_data;
    assign w_parityOk   = (w_parityAcc == i_cfg_data);
    assign w_wrEn       = w_beat && (w_curIdx <= LAST_DATA_IDX);
`else
    assign w_parityOk   = 1'b1;
    assign w_wrEn       = w_beat;
`endif

    // Next-state logic for the load FSM. A load finishes only when cfg_last
    // and the final index coincide (and parity matches when enabled); any
    // other combination involving cfg_last or the final index is malformed,
    // flags an error and throws the table away.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_errNext   = 1'b0;
        if (w_beat) begin
            if (i_cfg_last && w_isFinal && w_parityOk) begin
                w_nextState = READY;
                w_nextIdx   = '0;
            end else if (i_cfg_last || w_isFinal) begin
                w_nextState = EMPTY;
                w_nextIdx   = '0;
                w_errNext   = 1'b1;
            end else begin
                w_nextState = LOADING;
                w_nextIdx   = w_curIdx + 1'b1;
            end
        end
    end

    // State, index and handshake registers. cfg_ready is held low during
    // reset and comes up on the first clock edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_idx      <= '0;
            r_cfgReady <= 1'b0;
            r_outValid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_idx      <= w_nextIdx;
            r_cfgReady <= 1'b1;
            r_outValid <= w_lookup;
            r_err      <= w_errNext;
        end
    end

`ifdef LUT_PARITY_EN
    // Parity accumulator follows every accepted beat; it is reseeded by the
    // first beat of each load through w_parityAcc, so no explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= '0;
        end else if (w_beat) begin
            r_parity <= w_parityNext;
        end
    end
`endif

    // Table storage with word-wide writes and a registered entry read.
    lut_table_ram #(
        .IN_BITS   (IN_BITS),
        .OUT_BITS  (OUT_BITS),
        .WORD_BITS (WORD_BITS),
        .WADDR_W   (WADDR_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wrEn),
        .i_wr_addr (w_wrAddr),
        .i_wr_data (i_cfg_data),
        .i_rd_en   (w_lookup),
        .i_rd_addr (i_in_data),
        .o_rd_data (o_out_data)
    );

    assign o_cfg_ready = r_cfgReady;
    assign o_out_valid = r_outValid;
    assign o_loaded    = (r_state == READY);
    assign o_err       = r_err;

endmodule

// File: doc/lut_table_loader.md
# lut_table_loader

Runtime-programmable LUT neuron with its write path: accepts a truth table as a valid/ready word stream, stores it in a 2^IN_BITS × OUT_BITS distributed table, then answers registered lookups. It is the writer-side counterpart to the fixed ROM neurons in the LogicNets layers. It lets a quantum-readout network retune individual neurons without resynthesis, and sits between the configuration interconnect and the layer's neuron fan-in wiring.

## Interface
- IN_BITS, 6, neuron fan-in width; table depth D = 2^IN_BITS
- OUT_BITS, 1, neuron output width
- WORD_BITS, 8, config word width; must divide D·OUT_BITS; N = D·OUT_BITS/WORD_BITS data words (default 8)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config word present
- cfg_ready  out  1  block accepts config word
- cfg_data  in  WORD_BITS  config word
- cfg_last  in  1  marks final word of a table load
- in_valid  in  1  lookup request
- in_data  in  IN_BITS  lookup address (neuron input vector)
- out_valid  out  1  lookup result valid
- out_data  out  OUT_BITS  table entry for the requested address
- loaded  out  1  table complete and usable
- err  out  1  one-cycle pulse on malformed load

## Operation
- Config beat = cfg_valid && cfg_ready.
- Bit mapping: concatenated stream, word k supplies bits [k·WORD_BITS +: WORD_BITS], LSB first. Entry i occupies stream bits [i·OUT_BITS +: OUT_BITS].
- FSM states:
  - EMPTY: no valid table. First beat goes to LOADING, word index = 0.
  - LOADING: each beat writes word[idx] and increments idx.
  - READY: table valid.
- LOADING exits:
  - Beat with cfg_last at the expected final index goes to READY.
  - cfg_last early, or the final index without cfg_last, pulses err and goes to EMPTY.
- Any beat in READY starts a reload. loaded drops the next cycle and the word is written as index 0.
- Lookups are served only in READY with no config beat in the same cycle. Otherwise in_valid is dropped: no queueing, no backpressure.
- A simultaneous config beat and lookup in READY: the config beat wins and the lookup is discarded.
- cfg_ready = 1 in every state once out of reset.

## Timing
- Reset values: cfg_ready=0, out_valid=0, out_data=0, loaded=0, err=0, state=EMPTY, idx=0. Table contents are undefined and not reset.
- cfg_ready rises on the first clk edge after rst deasserts.
- Lookup latency is 1 cycle: request at edge t gives out_valid/out_data at t+1. Throughput is 1 per cycle.
- loaded rises the cycle after the accepted final beat. The first lookup is accepted that same cycle.
- err is a single-cycle pulse, registered one cycle after the offending beat.
- rst mid-load abandons the load; the table must be fully reloaded.

## Configuration
- LUT_PARITY_EN defined:
  - A load is N+1 beats. The final beat (with cfg_last) carries the XOR of the N data words.
  - A mismatch pulses err and goes to EMPTY, leaving loaded=0.
  - The parity word is not written to the table.
- LUT_PARITY_EN undefined: a load is exactly N beats with no integrity check.

## Structure
- Shared package lut_loader_pkg:
  - state enum {EMPTY, LOADING, READY}
  - function computing N from the parameters
  - IDX_W = clog2(N+1)
- One sub-module, lut_table_ram:
  - D×OUT_BITS distributed RAM with WORD_BITS-wide write port
  - registered read port, rom_style/ram_style distributed
- Top level holds the FSM, index counter, parity accumulator and handshake logic.

## Test plan
- Load eight words 0x55 with cfg_last on beat 8. Then loaded=1; lookup 6'b000000 returns 1 and 6'b000001 returns 0 one cycle later; back-to-back lookups return every cycle.
- cfg_last on beat 5 gives an err pulse, loaded=0, and lookups produce no out_valid.
- In READY, drive a config beat and in_valid in the same cycle. The lookup is dropped, loaded falls, and a subsequent 8-word 0xAA load inverts results (addr 0 returns 0).
- Assert rst after beat 4 of a load, then release. All outputs are at reset values, and a full reload is required before loaded=1.
- LUT_PARITY_EN: send eight words 0x55 then 0x00 as the final beat, which gives loaded=1. A final beat of 0x01 instead gives err and loaded=0.
- Random tables of random length: a scoreboard checks every lookup against a software model, including cfg_valid gaps mid-load.
